// File: rtl/plc_pump_ctrl_if.sv
// plc_pump_ctrl_if: field I/O bundle of the multi-channel pump controller.
// The master side drives the pressure words, buttons and thresholds; the
// slave side (the controller) returns motor, over-pressure and trip flags.
interface plc_pump_ctrl_if #(
    parameter int CHANNELS = 4,
    parameter int AW       = 16
);
    logic [CHANNELS*AW-1:0] a_in;
    logic [CHANNELS-1:0]    start_in;
    logic [CHANNELS-1:0]    stop_in;
    logic [AW-1:0]          thr_hi_in;
    logic [AW-1:0]          thr_lo_in;
    logic [CHANNELS-1:0]    motor_out;
    logic [CHANNELS-1:0]    max_out;
    logic [CHANNELS-1:0]    trip_out;

    modport master (
        output a_in, start_in, stop_in, thr_hi_in, thr_lo_in,
        input  motor_out, max_out, trip_out
    );

    modport slave (
        input  a_in, start_in, stop_in, thr_hi_in, thr_lo_in,
        output motor_out, max_out, trip_out
    );
endinterface

// File: rtl/plc_pump_ctrl.sv
// plc_pump_ctrl: independent pump channels sharing one pair of pressure
// thresholds. Each channel debounces its start/stop buttons, flags
// over-pressure with hysteresis and runs an IDLE/RUN/TRIP/LOCKOUT machine
// that drives the motor enable.
module plc_pump_ctrl #(
    parameter int CHANNELS       = 4,
    parameter int AW             = 16,
    parameter int DEB_CYCLES     = 8,
    parameter int LOCKOUT_CYCLES = 32
) (
    input  logic           clk_in,
    input  logic           rst_in,
    plc_pump_ctrl_if.slave bus
);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int LW = $clog2(LOCKOUT_CYCLES + 1);

    // The debounce counter commits on the cycle it would reach DEB_CYCLES,
    // so the stored count tops out at DEB_CYCLES-1 and can never wrap.
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCKOUT_CYCLES - 1);

    // One-hot so motor_out and trip_out each come straight from one flop.
    typedef enum logic [3:0] {
        IDLE    = 4'b0001,
        RUN     = 4'b0010,
        TRIP    = 4'b0100,
        LOCKOUT = 4'b1000
    } state_t;

    localparam int RUN_BIT  = 1;
    localparam int TRIP_BIT = 2;

    logic [CHANNELS-1:0] motor_v;
    logic [CHANNELS-1:0] max_v;
    logic [CHANNELS-1:0] trip_v;

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        logic [1:0]    raw;          // [0] start button, [1] stop button
        logic [1:0]    db;           // debounced copies, same order
        logic          start_db_prev;
        logic          start_edge;
        logic [AW-1:0] a_q;
        logic          max_q;
        state_t        state;
        state_t        state_nxt;
        logic [LW-1:0] lock_cnt;
        logic [LW-1:0] lock_cnt_nxt;

        assign raw = {bus.stop_in[ch], bus.start_in[ch]};

        for (genvar k = 0; k < 2; k++) begin : g_deb
            logic          sync_a;
            logic          sync_b;
            logic          db_q;
            logic [DW-1:0] cnt;

            // Two-flop synchroniser, then accept a new level only after it
            // has been seen for DEB_CYCLES consecutive cycles.
            always_ff @(posedge clk_in or negedge rst_in) begin
                if (!rst_in) begin
                    // Buttons come up "pressed" so a held start is not an
                    // edge and stop must be seen released before any start.
                    sync_a <= 1'b1;
                    sync_b <= 1'b1;
                    db_q   <= 1'b1;
                    cnt    <= '0;
                end else begin
                    // NOTE: non-blocking assignments let every flop sample
                    // the pre-edge value, which is what makes sync_a ->
                    // sync_b a real two-stage chain.
                    sync_a <= raw[k];
                    sync_b <= sync_a;
                    if (sync_b == db_q) begin
                        cnt <= '0;
                    end else if (cnt == DEB_LAST) begin
                        db_q <= sync_b;
                        cnt  <= '0;
                    end else begin
                        cnt <= cnt + DW'(1);
                    end
                end
            end

            assign db[k] = db_q;
        end

        // History of the debounced start for rising-edge detection.
        always_ff @(posedge clk_in or negedge rst_in) begin
            if (!rst_in) begin
                start_db_prev <= 1'b1;
            end else begin
                start_db_prev <= db[0];
            end
        end

        assign start_edge = db[0] & ~start_db_prev;

        // Register the pressure word and apply the hysteresis band; set
        // wins when misconfigured thresholds make both tests true.
        always_ff @(posedge clk_in or negedge rst_in) begin
            if (!rst_in) begin
                a_q   <= '0;
                max_q <= 1'b0;
            end else begin
                a_q <= bus.a_in[ch*AW +: AW];
                if (a_q >= bus.thr_hi_in) begin
                    max_q <= 1'b1;
                end else if (a_q <= bus.thr_lo_in) begin
                    max_q <= 1'b0;
                end
            end
        end

        // Channel state and lockout timer.
        always_ff @(posedge clk_in or negedge rst_in) begin
            if (!rst_in) begin
                state    <= IDLE;
                lock_cnt <= '0;
            end else begin
                state    <= state_nxt;
                lock_cnt <= lock_cnt_nxt;
            end
        end

        // Transition rules, listed in priority order; the timer only runs
        // while in LOCKOUT and is cleared everywhere else.
        always_comb begin
            // NOTE: every output of this block is given a default first, so
            // no path through the case can leave one unassigned and infer a
            // latch.
            state_nxt    = state;
            lock_cnt_nxt = '0;
            case (state)
                IDLE: begin
                    if (start_edge && !db[1] && !max_q) begin
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    if (max_q) begin
                        state_nxt = TRIP;
                    end else if (db[1]) begin
                        state_nxt = LOCKOUT;
                    end
                end
                TRIP: begin
                    if (!max_q) begin
                        state_nxt = LOCKOUT;
                    end
                end
                LOCKOUT: begin
                    if (lock_cnt == LOCK_LAST) begin
                        state_nxt = IDLE;
                    end else begin
                        lock_cnt_nxt = lock_cnt + LW'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end

        assign motor_v[ch] = state[RUN_BIT];
        assign trip_v[ch]  = state[TRIP_BIT];
        assign max_v[ch]   = max_q;
    end

    assign bus.motor_out = motor_v;
    assign bus.trip_out  = trip_v;
    assign bus.max_out   = max_v;
endmodule

// File: tb/tb_plc_pump_ctrl.sv
// tb_plc_pump_ctrl: directed scenarios followed by random button/pressure
// traffic, all compared every cycle against a behavioural channel model.
module tb_plc_pump_ctrl;
    localparam int CH   = 4;
    localparam int AW   = 16;
    localparam int DEB  = 8;
    localparam int LOCK = 32;
    localparam int HW   = DEB + 2;

    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_TRIP = 2;
    localparam int S_LOCK = 3;

    logic clk = 1'b0;
    logic rst_in;

    plc_pump_ctrl_if #(.CHANNELS(CH), .AW(AW)) bus ();

    plc_pump_ctrl #(
        .CHANNELS      (CH),
        .AW            (AW),
        .DEB_CYCLES    (DEB),
        .LOCKOUT_CYCLES(LOCK)
    ) dut (
        .clk_in(clk),
        .rst_in(rst_in),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int edge_n      = 0;

    // Reference model: raw-sample history per button (bit j = sample taken
    // j edges ago), debounced levels, state and the edge where lockout ends.
    int            m_state [CH];
    int            m_until [CH];
    logic          m_db_s  [CH];
    logic          m_db_p  [CH];
    logic          m_prev  [CH];
    logic          m_max   [CH];
    logic [AW-1:0] m_areg  [CH];
    logic [HW-1:0] m_hs    [CH];
    logic [HW-1:0] m_hp    [CH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h at edge %0d", tag, obs, exp, edge_n);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_state[c] = S_IDLE;
            m_until[c] = 0;
            m_db_s[c]  = 1'b1;
            m_db_p[c]  = 1'b1;
            m_prev[c]  = 1'b1;
            m_max[c]   = 1'b0;
            m_areg[c]  = '0;
            m_hs[c]    = '1;
            m_hp[c]    = '1;
        end
    endtask

    // The debounced level flips when the synchronised samples seen over the
    // last DEB edges (raw samples 2..DEB+1 edges old) all disagree with it.
    function automatic logic window_differs(input logic [HW-1:0] h, input logic db);
        for (int j = 2; j < HW; j++) begin
            if (h[j] == db) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_step();
        logic se;
        edge_n++;
        for (int c = 0; c < CH; c++) begin
            se = m_db_s[c] & ~m_prev[c];
            case (m_state[c])
                S_IDLE: if (se && !m_db_p[c] && !m_max[c]) m_state[c] = S_RUN;
                S_RUN: begin
                    if (m_max[c]) m_state[c] = S_TRIP;
                    else if (m_db_p[c]) begin
                        m_state[c] = S_LOCK;
                        m_until[c] = edge_n + LOCK;
                    end
                end
                S_TRIP: begin
                    if (!m_max[c]) begin
                        m_state[c] = S_LOCK;
                        m_until[c] = edge_n + LOCK;
                    end
                end
                default: if (edge_n == m_until[c]) m_state[c] = S_IDLE;
            endcase
            if (m_areg[c] >= bus.thr_hi_in) m_max[c] = 1'b1;
            else if (m_areg[c] <= bus.thr_lo_in) m_max[c] = 1'b0;
            m_areg[c] = bus.a_in[c*AW +: AW];
            m_prev[c] = m_db_s[c];
            m_hs[c] = {m_hs[c][HW-2:0], bus.start_in[c]};
            m_hp[c] = {m_hp[c][HW-2:0], bus.stop_in[c]};
            if (window_differs(m_hs[c], m_db_s[c])) m_db_s[c] = ~m_db_s[c];
            if (window_differs(m_hp[c], m_db_p[c])) m_db_p[c] = ~m_db_p[c];
        end
    endtask

    // One clock: model follows the rising edge, outputs compared at the
    // falling edge; stimulus changes only after this returns.
    task automatic cycle();
        logic [CH-1:0] em, et, ex;
        @(posedge clk);
        if (rst_in) model_step();
        else model_reset();
        @(negedge clk);
        for (int c = 0; c < CH; c++) begin
            em[c] = (m_state[c] == S_RUN);
            et[c] = (m_state[c] == S_TRIP);
            ex[c] = m_max[c];
        end
        check("model_motor", 32'(bus.motor_out), 32'(em));
        check("model_trip",  32'(bus.trip_out),  32'(et));
        check("model_max",   32'(bus.max_out),   32'(ex));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic set_a(input int c, input logic [AW-1:0] v);
        bus.a_in[c*AW +: AW] = v;
    endtask

    function automatic logic [AW-1:0] pick_a();
        case ($urandom_range(0, 5))
            0:       return bus.thr_hi_in;
            1:       return bus.thr_hi_in - AW'(1);
            2:       return bus.thr_lo_in;
            3:       return bus.thr_lo_in + AW'(1);
            default: return AW'($urandom);
        endcase
    endfunction

    task automatic random_phase(input int n);
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 24) == 0) bus.start_in[c] = ~bus.start_in[c];
                if ($urandom_range(0, 39) == 0) bus.stop_in[c] = ~bus.stop_in[c];
                if ($urandom_range(0, 29) == 0) set_a(c, pick_a());
            end
            cycle();
        end
    endtask

    initial begin
        rst_in        = 1'b0;
        bus.a_in      = {CH{16'h1000}};
        bus.start_in  = '0;
        bus.stop_in   = '0;
        bus.thr_hi_in = 16'hC000;
        bus.thr_lo_in = 16'hA000;
        model_reset();

        // Reset state
        run(3);
        check("rst_motor", 32'(bus.motor_out), 32'h0);
        check("rst_trip",  32'(bus.trip_out),  32'h0);
        check("rst_max",   32'(bus.max_out),   32'h0);
        rst_in = 1'b1;
        run(25);

        // 1. Start ch0 below threshold: motor exactly at edge 11
        set_a(0, 16'hBFFF);
        bus.start_in[0] = 1'b1;
        run(10);
        check("t1_motor0_edge10", 32'(bus.motor_out[0]), 32'h0);
        run(1);
        check("t1_motor0_edge11", 32'(bus.motor_out[0]), 32'h1);
        check("t1_motor_others",  32'(bus.motor_out[3:1]), 32'h0);
        check("t1_max0",          32'(bus.max_out[0]), 32'h0);
        bus.start_in[0] = 1'b0;
        run(12);

        // 2. Glitch rejection on start and on stop
        bus.start_in[1] = 1'b1;
        run(5);
        bus.start_in[1] = 1'b0;
        run(20);
        check("t2_start_glitch", 32'(bus.motor_out[1]), 32'h0);
        bus.stop_in[0] = 1'b1;
        run(5);
        bus.stop_in[0] = 1'b0;
        run(20);
        check("t2_stop_glitch", 32'(bus.motor_out[0]), 32'h1);

        // 3. Trip, hysteresis, lockout boundary on the late side
        set_a(0, 16'hC000);
        run(1);
        check("t3_max_edge1", 32'(bus.max_out[0]), 32'h0);
        run(1);
        check("t3_max_edge2",   32'(bus.max_out[0]),   32'h1);
        check("t3_motor_edge2", 32'(bus.motor_out[0]), 32'h1);
        run(1);
        check("t3_motor_edge3", 32'(bus.motor_out[0]), 32'h0);
        check("t3_trip_edge3",  32'(bus.trip_out[0]),  32'h1);
        set_a(0, 16'hB000);
        run(10);
        check("t3_band_max",  32'(bus.max_out[0]),  32'h1);
        check("t3_band_trip", 32'(bus.trip_out[0]), 32'h1);
        set_a(0, 16'hA000);
        run(2);
        check("t3_release_max",  32'(bus.max_out[0]),  32'h0);
        check("t3_release_trip", 32'(bus.trip_out[0]), 32'h1);
        run(1);
        check("t3_lockout_trip", 32'(bus.trip_out[0]), 32'h0);
        run(21);
        bus.start_in[0] = 1'b1;        // debounced edge lands on last lockout cycle
        run(11);
        check("t3_last_lockout_start", 32'(bus.motor_out[0]), 32'h0);
        run(3);
        check("t3_no_queued_start", 32'(bus.motor_out[0]), 32'h0);
        bus.start_in[0] = 1'b0;
        run(12);

        // 4. Lockout on ch2: early start discarded, start on first IDLE cycle accepted
        bus.start_in[2] = 1'b1;
        run(11);
        check("t4_run", 32'(bus.motor_out[2]), 32'h1);
        bus.start_in[2] = 1'b0;
        run(12);
        bus.stop_in[2] = 1'b1;
        run(10);
        check("t4_stop_edge10", 32'(bus.motor_out[2]), 32'h1);
        run(1);
        check("t4_stop_edge11", 32'(bus.motor_out[2]), 32'h0);
        bus.stop_in[2]  = 1'b0;
        bus.start_in[2] = 1'b1;
        run(12);
        check("t4_start_in_lockout", 32'(bus.motor_out[2]), 32'h0);
        bus.start_in[2] = 1'b0;
        run(10);
        bus.start_in[2] = 1'b1;        // debounced edge lands on first IDLE cycle
        run(10);
        check("t4_restart_edge10", 32'(bus.motor_out[2]), 32'h0);
        run(1);
        check("t4_restart_edge11", 32'(bus.motor_out[2]), 32'h1);
        bus.start_in[2] = 1'b0;
        run(12);

        // 5. Simultaneous events on ch3
        bus.start_in[3] = 1'b1;
        run(11);
        check("t5_run", 32'(bus.motor_out[3]), 32'h1);
        bus.start_in[3] = 1'b0;
        run(12);
        bus.stop_in[3] = 1'b1;
        run(8);
        set_a(3, 16'hC000);            // max rises on the same edge as stop_db
        run(2);
        check("t5_both_max",   32'(bus.max_out[3]),   32'h1);
        check("t5_both_motor", 32'(bus.motor_out[3]), 32'h1);
        run(1);
        check("t5_trip_wins",  32'(bus.trip_out[3]),  32'h1);
        check("t5_motor_off",  32'(bus.motor_out[3]), 32'h0);
        bus.stop_in[3] = 1'b0;
        set_a(3, 16'h9000);
        run(50);
        bus.stop_in[3] = 1'b1;
        run(12);
        bus.start_in[3] = 1'b1;
        run(15);
        check("t5_start_while_stop", 32'(bus.motor_out[3]), 32'h0);
        bus.start_in[3] = 1'b0;
        bus.stop_in[3]  = 1'b0;
        run(12);
        set_a(3, 16'hC000);
        run(3);
        bus.start_in[3] = 1'b1;
        run(15);
        check("t5_start_while_max", 32'(bus.motor_out[3]), 32'h0);
        check("t5_max_held",        32'(bus.max_out[3]),   32'h1);
        bus.start_in[3] = 1'b0;
        set_a(3, 16'h9000);
        run(12);

        // 6. Asynchronous reset mid-RUN with start held
        bus.start_in[0] = 1'b1;
        run(11);
        check("t6_run", 32'(bus.motor_out[0]), 32'h1);
        #2 rst_in = 1'b0;
        #1;
        model_reset();
        check("t6_async_motor", 32'(bus.motor_out), 32'h0);
        check("t6_async_trip",  32'(bus.trip_out),  32'h0);
        run(3);
        rst_in = 1'b1;
        run(40);
        check("t6_no_restart", 32'(bus.motor_out[0]), 32'h0);
        bus.start_in[0] = 1'b0;
        run(12);
        bus.start_in[0] = 1'b1;
        run(10);
        check("t6_repress_edge10", 32'(bus.motor_out[0]), 32'h0);
        run(1);
        check("t6_repress_edge11", 32'(bus.motor_out[0]), 32'h1);
        bus.start_in[0] = 1'b0;
        run(12);

        // Random traffic with normal, then inverted (misconfigured) thresholds
        random_phase(4000);
        bus.thr_hi_in = 16'h4000;
        bus.thr_lo_in = 16'h8000;
        random_phase(1500);
        bus.thr_hi_in = 16'hC000;
        bus.thr_lo_in = 16'hA000;
        random_phase(1500);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/plc_pump_ctrl.md
# plc_pump_ctrl

Parametrised multi-channel pump/motor controller for the PLC I/O path of the `up` system; it is the next generation of the single-channel pressure/start/stop/motor/max loop. Each channel does the following:
- synchronises and debounces its start and stop buttons;
- compares its unsigned analog pressure word against shared high/low thresholds with hysteresis;
- runs a per-channel start/stop/trip/lockout state machine that drives the motor enable.

All channels are independent and identical; only the thresholds are shared.

## Interface

Parameters:
- CHANNELS, 4, number of independent pump channels (≥1)
- AW, 16, analog word width in bits
- DEB_CYCLES, 8, cycles an input must be stable after synchronisation before the debounced value changes (≥1)
- LOCKOUT_CYCLES, 32, restart lockout length in cycles after any stop or trip (≥1)

Ports:
- clk_in  input  1  system clock; all state updates on the rising edge
- rst_in  input  1  asynchronous, active-low reset
- a_in  input  CHANNELS*AW  pressure words; channel k is at [k*AW +: AW]; unsigned
- start_in  input  CHANNELS  raw start buttons, active-high, asynchronous to clk_in
- stop_in  input  CHANNELS  raw stop buttons, active-high, asynchronous to clk_in
- thr_hi_in  input  AW  trip threshold, shared by all channels
- thr_lo_in  input  AW  trip-release threshold, shared by all channels
- motor_out  output  CHANNELS  motor enable, 1 only in RUN
- max_out  output  CHANNELS  over-pressure flag, with hysteresis
- trip_out  output  CHANNELS  1 only in TRIP

## Operation

**Reset** (rst_in=0, effective immediately):
- state=IDLE; motor_out, max_out and trip_out are all 0.
- Lockout counters and debounce counters are 0.
- The start and stop synchronisers, their debounced values, and the start edge-detect history all reset to 1. This is fail-safe: a start held through reset is not an edge, and the channel cannot start until stop has debounced low.

**Debounce**, per input:
- 2-flop synchroniser feeding a counter.
- The counter increments while the synchronised value differs from the debounced value, and clears when they match.
- When the counter reaches DEB_CYCLES, the debounced value takes the new value and the counter clears.
- start_edge = start_db & ~start_db_prev.

**Comparator**, per channel:
- a_in is registered.
- max sets when a ≥ thr_hi, clears when a ≤ thr_lo, and otherwise holds.
- If both conditions are true (misconfigured thresholds), set wins.

**FSM**, per channel; the listed order is the priority order:
- IDLE: start_edge & ~stop_db & ~max → RUN. Otherwise stay.
- RUN: max → TRIP (wins over a simultaneous stop). Else stop_db → LOCKOUT.
- TRIP: ~max → LOCKOUT. stop and start are ignored.
- LOCKOUT: count LOCKOUT_CYCLES cycles, then → IDLE. start edges during LOCKOUT are discarded, not queued.

**Outputs:**
- motor_out and trip_out decode directly from the state flops.
- max_out is the comparator flop.
- All three are glitch-free.

**Counter widths:** $clog2(param+1); counters never wrap.

## Timing

Edge numbering: edge 1 is the first rising clk_in edge at which the new input value is sampled.

- Debounced input changes at edge DEB_CYCLES+2 if the raw input is held stable. Any reversion earlier than that leaves the debounced value unchanged.
- start → motor_out=1 at edge DEB_CYCLES+3 (11 with defaults).
- stop → motor_out=0 at edge DEB_CYCLES+3.
- Pressure crossing → max_out changes at edge 2.
- Pressure crossing in RUN → motor_out=0 and trip_out=1 at edge 3.
- Pressure release in TRIP → trip_out=0 at edge 3, as the state enters LOCKOUT.
- LOCKOUT occupies exactly LOCKOUT_CYCLES cycles; a start edge is accepted from the first IDLE cycle onward.
- A reset asserted mid-RUN drops motor_out asynchronously, without waiting for a clock edge.
- After reset release with start_in=stop_in=0, both debounced values fall at edge DEB_CYCLES+2; start is accepted only after that.

## Test plan

All scenarios use defaults, thr_hi=0xC000, thr_lo=0xA000, and wait ≥20 cycles after reset release before stimulus.

1. **Start:** a0=0xBFFF, start_in[0] raised and held → motor_out[0]=1 exactly 11 edges later; channels 1–3 motor_out stay 0; max_out[0] stays 0 (0xBFFF is below threshold).
2. **Glitch rejection:** start_in[1] high for 5 cycles then low → motor_out[1] never asserts. A stop pulse of 5 cycles in RUN → motor stays 1.
3. **Trip and hysteresis:** ch0 in RUN, a0=0xC000 → max_out[0]=1 at edge 2, motor_out[0]=0 and trip_out[0]=1 at edge 3. Then:
   - a0=0xB000: max stays 1 and the channel stays in TRIP.
   - a0=0xA000: max clears, trip_out falls, LOCKOUT lasts 32 cycles, then IDLE.
4. **Lockout:** stop ch2 from RUN; new start edge 10 cycles into LOCKOUT → ignored, motor stays 0; new start edge after lockout expires → motor_out[2]=1 at edge 11.
5. **Simultaneous events:** in RUN, stop_db and max rising on the same cycle → TRIP, not LOCKOUT. In IDLE, start edge while stop_db=1, or while max=1 → no start.
6. **Reset:** rst_in=0 mid-RUN with start held → motor_out=0 asynchronously. After release with start still held → no restart. Release start, debounce low, press again → RUN.
